// File: rtl/uart_flow_endpoint.sv
// UART link partner: 8N1 transmitter/receiver with RTS/CTS flow control,
// show-ahead RX FIFO and sticky framing/overflow error flag.
module uart_flow_endpoint #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       err_clr,
  input  logic       rx,
  output logic       tx,
  input  logic       cts,
  output logic       rts,
  output logic       err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   RTS_MAX   = (PTR_W + 1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  logic rx_meta, rx_sync, rx_prev;
  logic cts_meta, cts_sync;

  tx_state_t        tx_state;
  logic [7:0]       tx_shift;
  logic [CNT_W-1:0] tx_div;
  logic [2:0]       tx_bit;

  rx_state_t        rx_state;
  logic [7:0]       rx_shift;
  logic [CNT_W-1:0] rx_div;
  logic [2:0]       rx_bit;
  logic             rx_tick, rx_push, frame_err;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             pop, full, push_ok, overflow;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      cts_meta <= cts;
      cts_sync <= cts_meta;
    end
  end

  // tx_ready is loaded on the STOP-completion edge so a new handshake can land
  // on the very next edge (10*CLK_DIV+1 cycle spacing).
  always_ff @(posedge clk) begin
    if (!nReset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_shift <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx     <= 1'b1;
          tx_div <= '0;
          tx_bit <= '0;
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end else begin
            tx_ready <= cts_sync;
          end
        end
        TX_START: begin
          if (tx_div == BIT_LAST) begin
            tx_div   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_div == BIT_LAST) begin
            tx_div <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_div == BIT_LAST) begin
            tx_div   <= '0;
            tx_ready <= cts_sync;
            tx_state <= TX_IDLE;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Stop-bit outcome is decoded combinationally so the FIFO acts on the sample edge.
  always_comb begin
    rx_tick   = (rx_div == BIT_LAST);
    rx_push   = (rx_state == RX_STOP) && rx_tick && rx_sync;
    frame_err = (rx_state == RX_STOP) && rx_tick && !rx_sync;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_div <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_div == HALF_LAST) begin
            rx_div   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_div   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_div   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (!rx_sync) begin
            rx_div <= '0;
          end else if (rx_tick) begin
            rx_div   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_div <= rx_div + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_comb begin
    pop        = rx_valid && rx_ready;
    full       = (count == FULL_CNT);
    push_ok    = rx_push && (!full || pop);
    overflow   = rx_push && full && !pop;
    count_next = count;
    if (push_ok && !pop)      count_next = count + 1'b1;
    else if (!push_ok && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rts    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      rts   <= (count_next <= RTS_MAX);
      if (frame_err || overflow) err <= 1'b1;
      else if (err_clr)          err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_flow_endpoint.sv
// Self-checking bench for uart_flow_endpoint: TX timing, CTS blocking, loopback,
// overflow, framing error, false start and mid-frame reset, with an RX scoreboard.
module tb_uart_flow_endpoint;

  localparam int D = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;
  logic       cts_drv = 1'b0;
  logic       tx_ready, rx_valid, tx, rts, err;
  logic [7:0] rx_data;
  logic       rx_line, cts_line;

  logic [7:0] exp_q[$];
  int         check_cnt = 0;
  int         pass_cnt = 0;

  assign rx_line  = loop_en ? tx  : rx_drv;
  assign cts_line = loop_en ? rts : cts_drv;

  always #5 clk = ~clk;

  uart_flow_endpoint #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nReset(nReset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_clr(err_clr), .rx(rx_line), .tx(tx), .cts(cts_line), .rts(rts), .err(err)
  );

  // Drive one 8N1 frame on rx starting at a negedge; optionally pop the FIFO on
  // the edge where the stop bit is sampled (2-flop sync + edge detect + half bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    logic [7:0] e;
    @(negedge clk) rx_drv = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (D) @(negedge clk);
    end
    rx_drv = stop;
    if (pop_at_stop) begin
      repeat (D / 2 + 2) @(negedge clk);
      e = exp_q.pop_front();
      check_cnt++; if (rx_data !== e) $display("FAIL pop_at_push_head: got %h want %h", rx_data, e); else pass_cnt++;
      rx_ready = 1'b1;
      exp_q.push_back(b);
      @(negedge clk) rx_ready = 1'b0;
      repeat (D / 2 - 3) @(negedge clk);
    end else begin
      repeat (D) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset();
    int k;
    nReset = 1'b0; cts_drv = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
    check_cnt++; if (rts !== 1'b0) $display("FAIL reset_rts: got %b want 0", rts); else pass_cnt++;
    check_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    check_cnt++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) $display("FAIL reset_rx: got %b/%h want 0/00", rx_valid, rx_data); else pass_cnt++;
    nReset = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 3) begin @(negedge clk); k++; end
    check_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1 within 3 cycles", tx_ready); else pass_cnt++;
    check_cnt++; if (rts !== 1'b1) $display("FAIL reset_release_rts: got %b want 1", rts); else pass_cnt++;
  endtask

  task automatic test_tx();
    logic [9:0] frame;
    int k;
    frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk) begin tx_data = 8'hA5; tx_valid = 1'b1; end
    @(negedge clk) tx_valid = 1'b0;
    for (int c = 0; c < 10 * D; c++) begin
      check_cnt++; if (tx !== frame[c / D] || tx_ready !== 1'b0)
        $display("FAIL tx_frame cycle %0d: got tx=%b rdy=%b want tx=%b rdy=0", c, tx, tx_ready, frame[c / D]);
      else pass_cnt++;
      @(negedge clk);
    end
    k = 10 * D;
    while (tx_ready !== 1'b1 && k < 10 * D + 3) begin @(negedge clk); k++; end
    check_cnt++; if (tx_ready !== 1'b1 || k < 10 * D) $display("FAIL tx_ready_return: got %b at %0d want 1 at >=%0d", tx_ready, k, 10 * D); else pass_cnt++;
  endtask

  task automatic test_tx_cts_blocked();
    bit bad;
    cts_drv = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt++; if (tx_ready !== 1'b0) $display("FAIL cts_block_ready: got %b want 0", tx_ready); else pass_cnt++;
    tx_data = 8'hA5; tx_valid = 1'b1; bad = 1'b0;
    repeat (30) begin @(negedge clk); if (tx_ready !== 1'b0 || tx !== 1'b1) bad = 1'b1; end
    check_cnt++; if (bad) $display("FAIL cts_block_line: got ready/tx activity want ready=0 tx=1"); else pass_cnt++;
    tx_valid = 1'b0; cts_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    logic [7:0] e;
    int t;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    loop_en = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (tx_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      check_cnt++; if (tx_ready !== 1'b1) $display("FAIL loop_ready_%0d: got %b want 1 (timeout)", i, tx_ready); else pass_cnt++;
      tx_data = bytes[i]; tx_valid = 1'b1;
      exp_q.push_back(bytes[i]);
      @(negedge clk) tx_valid = 1'b0;
    end
    repeat (10 * D + 20) @(negedge clk);
    check_cnt++; if (rts !== 1'b0) $display("FAIL loop_rts_after_3: got %b want 0", rts); else pass_cnt++;
    check_cnt++; if (tx_ready !== 1'b0) $display("FAIL loop_tx_blocked: got %b want 0", tx_ready); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL loop_rx_data: got %b/%h want 1/%h", rx_valid, rx_data, e); else pass_cnt++;
      rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
      @(negedge clk);
    end
    check_cnt++; if (rx_valid !== 1'b0 || err !== 1'b0) $display("FAIL loop_end: got valid=%b err=%b want 0/0", rx_valid, err); else pass_cnt++;
    check_cnt++; if (rts !== 1'b1) $display("FAIL loop_rts_restored: got %b want 1", rts); else pass_cnt++;
    loop_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] ov [5];
    logic [7:0] e;
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(ov[i]);
      send_frame(ov[i], 1'b1, 1'b0);
      if (i == DEPTH - 1) begin
        check_cnt++; if (err !== 1'b0 || rts !== 1'b0) $display("FAIL ovf_full_state: got err=%b rts=%b want 0/0", err, rts); else pass_cnt++;
      end
    end
    repeat (2) @(negedge clk);
    check_cnt++; if (err !== 1'b1) $display("FAIL ovf_err_set: got %b want 1", err); else pass_cnt++;
    err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    check_cnt++; if (err !== 1'b0) $display("FAIL ovf_err_clr: got %b want 0", err); else pass_cnt++;
    send_frame(8'h66, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_cnt++; if (err !== 1'b0) $display("FAIL ovf_pop_push_err: got %b want 0", err); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL ovf_drain: got %b/%h want 1/%h", rx_valid, rx_data, e); else pass_cnt++;
      rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
    end
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovf_empty: got %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_framing();
    logic [7:0] e;
    send_frame(8'h55, 1'b0, 1'b0);
    check_cnt++; if (err !== 1'b1) $display("FAIL frame_err_set: got %b want 1", err); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0) $display("FAIL frame_no_push: got %b want 0", rx_valid); else pass_cnt++;
    repeat (7) @(negedge clk);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL frame_recover: got %b/%h want 1/%h", rx_valid, rx_data, e); else pass_cnt++;
    rx_ready = 1'b1; err_clr = 1'b1;
    @(negedge clk) begin rx_ready = 1'b0; err_clr = 1'b0; end
    check_cnt++; if (err !== 1'b0 || rx_valid !== 1'b0) $display("FAIL frame_cleanup: got err=%b valid=%b want 0/0", err, rx_valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [7:0] e;
    @(negedge clk) rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * D) @(negedge clk);
    check_cnt++; if (rx_valid !== 1'b0 || err !== 1'b0) $display("FAIL glitch_ignored: got valid=%b err=%b want 0/0", rx_valid, err); else pass_cnt++;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    check_cnt++; if (rx_valid !== 1'b1 || rx_data !== e) $display("FAIL glitch_next_frame: got %b/%h want 1/%h", rx_valid, rx_data, e); else pass_cnt++;
    rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check_cnt++; if (tx_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1 (timeout)", tx_ready); else pass_cnt++;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk) tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++; if (tx !== 1'b0) $display("FAIL midrst_start_bit: got %b want 0", tx); else pass_cnt++;
    nReset = 1'b0;
    @(posedge clk) #1;
    check_cnt++; if (tx !== 1'b1 || tx_ready !== 1'b0) $display("FAIL midrst_abort: got tx=%b rdy=%b want 1/0", tx, tx_ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    repeat (5) @(negedge clk);
    check_cnt++; if (tx !== 1'b1) $display("FAIL midrst_idle_line: got %b want 1", tx); else pass_cnt++;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion (%0d/%0d)", pass_cnt, check_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx();
    test_tx_cts_blocked();
    test_loopback();
    test_overflow();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
